// File: rtl/riscv_pkg.sv
// riscv_pkg: register-index type, ALU op encodings and the ID/EX register layout
// shared by the ID/EX pipeline slice.
package riscv_pkg;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_X0  = 5'd0;
    localparam int       NUM_SRC = 2;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SR  = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic        valid;
        reg_idx_t    rs1;
        reg_idx_t    rs2;
        reg_idx_t    rd;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        src_a_pc;
        logic        src_b_imm;
        alu_op_e     alu_ctrl;
        logic        funct7_bit;
        logic        funct3_bit0;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } id_ex_t;

    // True when a used source reads a non-x0 register that rd is about to write.
    function automatic logic reg_dep(input logic use_rs, input reg_idx_t rs, input reg_idx_t rd);
        return use_rs && (rs != REG_X0) && (rs == rd);
    endfunction

endpackage

// File: rtl/forward_unit.sv
// forward_unit: selects the freshest value for one EX source register.
// MEM-stage result beats WB-stage result; x0 is never bypassed.
module forward_unit
    import riscv_pkg::*;
(
    input  logic [4:0]  rs,
    input  logic [31:0] rf_data,
    input  logic        mem_reg_write,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_result,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_result,
    output logic [31:0] fwd_data
);

    always_comb begin
        fwd_data = rf_data;
        if (mem_reg_write && (mem_rd == rs) && (rs != REG_X0)) begin
            fwd_data = mem_result;
        end else if (wb_reg_write && (wb_rd == rs) && (rs != REG_X0)) begin
            fwd_data = wb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with hazard bubbles and operand selection.
// Define FORWARDING_EN for MEM/WB bypassing; without it every in-flight writer stalls decode.
module id_ex_stage
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_valid,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    input  logic        dec_use_rs1,
    input  logic        dec_use_rs2,
    input  logic [31:0] dec_rs1_data,
    input  logic [31:0] dec_rs2_data,
    input  logic [31:0] dec_imm,
    input  logic [31:0] dec_pc,
    input  logic        dec_src_a_pc,
    input  logic        dec_src_b_imm,
    input  logic [2:0]  dec_alu_ctrl,
    input  logic        dec_funct7_bit,
    input  logic        dec_funct3_bit0,
    input  logic        dec_reg_write,
    input  logic        dec_mem_read,
    input  logic        dec_mem_write,
    input  logic        mem_reg_write,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_result,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_result,
    input  logic        ex_stall,
    input  logic        ex_flush,
    output logic        dec_ready,
    output logic        ex_valid,
    output logic [31:0] ex_src_a,
    output logic [31:0] ex_src_b,
    output logic [31:0] ex_store_data,
    output logic [31:0] ex_pc,
    output logic [2:0]  ex_alu_ctrl,
    output logic        ex_funct7_bit,
    output logic        ex_funct3_bit0,
    output logic [4:0]  ex_rd,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic [31:0] stall_cnt
);

    id_ex_t      ex_reg, ex_next, dec_fields;
    logic [31:0] stall_cnt_reg, stall_cnt_next;
    logic        load_use, hazard;

    // A load in EX cannot supply its data to the very next instruction.
    assign load_use = ex_reg.valid && ex_reg.mem_read &&
                      (reg_dep(dec_use_rs1, dec_rs1, ex_reg.rd) ||
                       reg_dep(dec_use_rs2, dec_rs2, ex_reg.rd));

`ifdef FORWARDING_EN
    localparam logic FWD_EN = 1'b1;

    assign hazard = dec_valid && load_use;
`else
    localparam logic FWD_EN = 1'b0;

    logic ex_dep, mem_dep, wb_dep;

    assign ex_dep  = ex_reg.valid && ex_reg.reg_write &&
                     (reg_dep(dec_use_rs1, dec_rs1, ex_reg.rd) || reg_dep(dec_use_rs2, dec_rs2, ex_reg.rd));
    assign mem_dep = mem_reg_write &&
                     (reg_dep(dec_use_rs1, dec_rs1, mem_rd) || reg_dep(dec_use_rs2, dec_rs2, mem_rd));
    assign wb_dep  = wb_reg_write &&
                     (reg_dep(dec_use_rs1, dec_rs1, wb_rd) || reg_dep(dec_use_rs2, dec_rs2, wb_rd));
    assign hazard  = dec_valid && (load_use || ex_dep || mem_dep || wb_dep);
`endif

    always_comb begin
        dec_fields             = '0;
        dec_fields.valid       = dec_valid;
        dec_fields.rs1         = dec_rs1;
        dec_fields.rs2         = dec_rs2;
        dec_fields.rd          = dec_rd;
        dec_fields.rs1_data    = dec_rs1_data;
        dec_fields.rs2_data    = dec_rs2_data;
        dec_fields.imm         = dec_imm;
        dec_fields.pc          = dec_pc;
        dec_fields.src_a_pc    = dec_src_a_pc;
        dec_fields.src_b_imm   = dec_src_b_imm;
        dec_fields.alu_ctrl    = alu_op_e'(dec_alu_ctrl);
        dec_fields.funct7_bit  = dec_funct7_bit;
        dec_fields.funct3_bit0 = dec_funct3_bit0;
        dec_fields.reg_write   = dec_valid & dec_reg_write;
        dec_fields.mem_read    = dec_valid & dec_mem_read;
        dec_fields.mem_write   = dec_valid & dec_mem_write;
    end

    // Flush beats stall beats hazard; a bubble only clears valid and the side-effect controls.
    always_comb begin
        ex_next        = ex_reg;
        stall_cnt_next = stall_cnt_reg;
        dec_ready      = 1'b0;
        if (rst) begin
            dec_ready = 1'b0;
        end else if (ex_flush) begin
            ex_next.valid     = 1'b0;
            ex_next.reg_write = 1'b0;
            ex_next.mem_read  = 1'b0;
            ex_next.mem_write = 1'b0;
            dec_ready         = 1'b1;
        end else if (ex_stall) begin
            dec_ready = 1'b0;
        end else if (hazard) begin
            ex_next.valid     = 1'b0;
            ex_next.reg_write = 1'b0;
            ex_next.mem_read  = 1'b0;
            ex_next.mem_write = 1'b0;
            stall_cnt_next    = stall_cnt_reg + 32'd1;
        end else begin
            ex_next   = dec_fields;
            dec_ready = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_reg        <= '0;
            stall_cnt_reg <= '0;
        end else begin
            ex_reg        <= ex_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    logic [4:0]  fwd_idx  [NUM_SRC];
    logic [31:0] fwd_rf   [NUM_SRC];
    logic [31:0] fwd_data [NUM_SRC];

    assign fwd_idx[0] = ex_reg.rs1;
    assign fwd_idx[1] = ex_reg.rs2;
    assign fwd_rf[0]  = ex_reg.rs1_data;
    assign fwd_rf[1]  = ex_reg.rs2_data;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_fwd
            forward_unit u_forward_unit (
                .rs            (fwd_idx[gi]),
                .rf_data       (fwd_rf[gi]),
                .mem_reg_write (mem_reg_write & FWD_EN),
                .mem_rd        (mem_rd),
                .mem_result    (mem_result),
                .wb_reg_write  (wb_reg_write & FWD_EN),
                .wb_rd         (wb_rd),
                .wb_result     (wb_result),
                .fwd_data      (fwd_data[gi])
            );
        end
    endgenerate

    assign ex_valid       = ex_reg.valid;
    assign ex_src_a       = ex_reg.src_a_pc  ? ex_reg.pc  : fwd_data[0];
    assign ex_src_b       = ex_reg.src_b_imm ? ex_reg.imm : fwd_data[1];
    assign ex_store_data  = fwd_data[1];
    assign ex_pc          = ex_reg.pc;
    assign ex_alu_ctrl    = ex_reg.alu_ctrl;
    assign ex_funct7_bit  = ex_reg.funct7_bit;
    assign ex_funct3_bit0 = ex_reg.funct3_bit0;
    assign ex_rd          = ex_reg.rd;
    assign ex_reg_write   = ex_reg.reg_write;
    assign ex_mem_read    = ex_reg.mem_read;
    assign ex_mem_write   = ex_reg.mem_write;
    assign stall_cnt      = stall_cnt_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized checks of id_ex_stage against a behavioural model.
// Honours FORWARDING_EN the same way as the design.
module tb_id_ex_stage;
    import riscv_pkg::*;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dec_valid, dec_use_rs1, dec_use_rs2, dec_src_a_pc, dec_src_b_imm;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd, mem_rd, wb_rd;
    logic [31:0] dec_rs1_data, dec_rs2_data, dec_imm, dec_pc, mem_result, wb_result;
    logic [2:0]  dec_alu_ctrl;
    logic        dec_funct7_bit, dec_funct3_bit0, dec_reg_write, dec_mem_read, dec_mem_write;
    logic        mem_reg_write, wb_reg_write, ex_stall, ex_flush;
    logic        dec_ready, ex_valid, ex_funct7_bit, ex_funct3_bit0;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;
    logic [31:0] ex_src_a, ex_src_b, ex_store_data, ex_pc, stall_cnt;
    logic [2:0]  ex_alu_ctrl;
    logic [4:0]  ex_rd;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the instruction sitting in EX
    bit          m_valid, m_rw, m_mr, m_mw, m_apc, m_bimm, m_f7, m_f3;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    logic [31:0] m_d1, m_d2, m_imm, m_pc, m_cnt;
    logic [2:0]  m_alu;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
        .dec_rs1_data(dec_rs1_data), .dec_rs2_data(dec_rs2_data), .dec_imm(dec_imm), .dec_pc(dec_pc),
        .dec_src_a_pc(dec_src_a_pc), .dec_src_b_imm(dec_src_b_imm), .dec_alu_ctrl(dec_alu_ctrl),
        .dec_funct7_bit(dec_funct7_bit), .dec_funct3_bit0(dec_funct3_bit0),
        .dec_reg_write(dec_reg_write), .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .ex_stall(ex_stall), .ex_flush(ex_flush), .dec_ready(dec_ready),
        .ex_valid(ex_valid), .ex_src_a(ex_src_a), .ex_src_b(ex_src_b), .ex_store_data(ex_store_data),
        .ex_pc(ex_pc), .ex_alu_ctrl(ex_alu_ctrl), .ex_funct7_bit(ex_funct7_bit),
        .ex_funct3_bit0(ex_funct3_bit0), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .stall_cnt(stall_cnt)
    );

    // Freshest value of a register as seen from EX this cycle.
    function automatic logic [31:0] m_fwd(input logic [4:0] idx, input logic [31:0] rf);
        if (FWD && idx != 5'd0 && mem_reg_write && mem_rd == idx) return mem_result;
        if (FWD && idx != 5'd0 && wb_reg_write && wb_rd == idx) return wb_result;
        return rf;
    endfunction

    // Registers whose new value decode may not read yet.
    function automatic bit m_hazard();
        logic [4:0] busy[$];
        if (m_valid && m_mr) busy.push_back(m_rd);
        if (!FWD && m_valid && m_rw) busy.push_back(m_rd);
        if (!FWD && mem_reg_write) busy.push_back(mem_rd);
        if (!FWD && wb_reg_write) busy.push_back(wb_rd);
        if (!dec_valid) return 1'b0;
        foreach (busy[i]) begin
            if (busy[i] != 5'd0 && ((dec_use_rs1 && dec_rs1 == busy[i]) || (dec_use_rs2 && dec_rs2 == busy[i])))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    // One clock edge; the model follows the decision the stage must make at that edge.
    task automatic step();
        bit hz;
        hz = m_hazard();
        @(posedge clk);
        if (rst) begin
            {m_valid, m_rw, m_mr, m_mw, m_apc, m_bimm, m_f7, m_f3} = '0;
            m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_alu = 0;
            m_d1 = 0; m_d2 = 0; m_imm = 0; m_pc = 0; m_cnt = 0;
        end else if (ex_flush) begin
            {m_valid, m_rw, m_mr, m_mw} = '0;
        end else if (ex_stall) begin
            m_valid = m_valid;
        end else if (hz) begin
            {m_valid, m_rw, m_mr, m_mw} = '0;
            m_cnt = m_cnt + 32'd1;
        end else begin
            m_valid = dec_valid; m_rw = dec_valid & dec_reg_write;
            m_mr = dec_valid & dec_mem_read; m_mw = dec_valid & dec_mem_write;
            m_rd = dec_rd; m_rs1 = dec_rs1; m_rs2 = dec_rs2; m_d1 = dec_rs1_data; m_d2 = dec_rs2_data;
            m_imm = dec_imm; m_pc = dec_pc; m_apc = dec_src_a_pc; m_bimm = dec_src_b_imm;
            m_alu = dec_alu_ctrl; m_f7 = dec_funct7_bit; m_f3 = dec_funct3_bit0;
        end
        #1;
    endtask

    task automatic idle();
        dec_valid = 0; mem_reg_write = 0; wb_reg_write = 0; ex_stall = 0; ex_flush = 0;
    endtask

    task automatic set_dec(input logic [4:0] rs1, rs2, rd, input logic use1, use2,
                           input logic [31:0] d1, d2, imm, pc, input logic apc, bimm,
                           input logic [2:0] alu, input logic rw, mr, mw);
        dec_valid = 1; dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd; dec_use_rs1 = use1; dec_use_rs2 = use2;
        dec_rs1_data = d1; dec_rs2_data = d2; dec_imm = imm; dec_pc = pc;
        dec_src_a_pc = apc; dec_src_b_imm = bimm; dec_alu_ctrl = alu;
        dec_funct7_bit = 0; dec_funct3_bit0 = 0; dec_reg_write = rw; dec_mem_read = mr; dec_mem_write = mw;
    endtask

    task automatic test_reset();
        rst = 1; step();
        n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", ex_valid); end
        n_checks++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %h expected 0", stall_cnt); end
        n_checks++; if (dec_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", dec_ready); end
        n_checks++; if (ex_src_a !== 32'd0) begin n_fail++; $display("FAIL reset_src_a: got %h expected 0", ex_src_a); end
        rst = 0;
        $display("txn reset: ex_valid=%0b stall_cnt=%0d", ex_valid, stall_cnt);
    endtask

    task automatic test_add();
        set_dec(5'd1, 5'd2, 5'd3, 1, 1, 32'd5, 32'd7, 32'd0, 32'h100, 0, 0, ALU_ADD, 1, 0, 0);
        #1;
        n_checks++; if (dec_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready: got %b expected 1", dec_ready); end
        step();
        n_checks++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b expected 1", ex_valid); end
        n_checks++; if (ex_src_a !== 32'd5) begin n_fail++; $display("FAIL add_src_a: got %h expected 5", ex_src_a); end
        n_checks++; if (ex_src_b !== 32'd7) begin n_fail++; $display("FAIL add_src_b: got %h expected 7", ex_src_b); end
        n_checks++; if (ex_alu_ctrl !== 3'b000) begin n_fail++; $display("FAIL add_alu: got %b expected 000", ex_alu_ctrl); end
        n_checks++; if (ex_rd !== 5'd3) begin n_fail++; $display("FAIL add_rd: got %0d expected 3", ex_rd); end
        set_dec(5'd1, 5'd2, 5'd7, 1, 1, 32'd5, 32'd7, 32'h10, 32'h200, 1, 1, ALU_SUB, 1, 0, 0);
        step();
        n_checks++; if (ex_src_a !== 32'h200) begin n_fail++; $display("FAIL pcimm_src_a: got %h expected 200", ex_src_a); end
        n_checks++; if (ex_src_b !== 32'h10) begin n_fail++; $display("FAIL pcimm_src_b: got %h expected 10", ex_src_b); end
        n_checks++; if (ex_store_data !== 32'd7) begin n_fail++; $display("FAIL pcimm_store: got %h expected 7", ex_store_data); end
        n_checks++; if (ex_alu_ctrl !== 3'b001) begin n_fail++; $display("FAIL pcimm_alu: got %b expected 001", ex_alu_ctrl); end
        $display("txn add: src_a=%h src_b=%h", ex_src_a, ex_src_b);
    endtask

    task automatic test_mem_priority();
        set_dec(5'd3, 5'd0, 5'd6, 1, 0, 32'h55, 32'd0, 32'd0, 32'h300, 0, 0, ALU_ADD, 1, 0, 0);
        step();
        dec_valid = 0;
        mem_reg_write = 1; mem_rd = 5'd3; mem_result = 32'h0C;
        wb_reg_write = 1; wb_rd = 5'd3; wb_result = 32'h99;
        #1;
        n_checks++; if (ex_src_a !== (FWD ? 32'h0C : 32'h55)) begin n_fail++; $display("FAIL mem_prio: got %h expected %h", ex_src_a, FWD ? 32'h0C : 32'h55); end
        mem_reg_write = 0; #1;
        n_checks++; if (ex_src_a !== (FWD ? 32'h99 : 32'h55)) begin n_fail++; $display("FAIL wb_fwd: got %h expected %h", ex_src_a, FWD ? 32'h99 : 32'h55); end
        $display("txn mem_priority: src_a=%h", ex_src_a);
        idle(); step();
    endtask

    task automatic test_x0();
        set_dec(5'd0, 5'd0, 5'd8, 1, 1, 32'd0, 32'd0, 32'd0, 32'h400, 0, 0, ALU_ADD, 1, 0, 0);
        step();
        dec_valid = 0;
        mem_reg_write = 1; mem_rd = 5'd0; mem_result = 32'hFFFF_FFFF;
        wb_reg_write = 1; wb_rd = 5'd0; wb_result = 32'h1234;
        #1;
        n_checks++; if (ex_src_a !== 32'd0) begin n_fail++; $display("FAIL x0_src_a: got %h expected 0", ex_src_a); end
        n_checks++; if (ex_store_data !== 32'd0) begin n_fail++; $display("FAIL x0_store: got %h expected 0", ex_store_data); end
        $display("txn x0: src_a=%h", ex_src_a);
        idle(); step();
    endtask

    task automatic test_load_use();
        logic [31:0] cnt0;
        set_dec(5'd1, 5'd0, 5'd4, 1, 0, 32'h1000, 32'd0, 32'd8, 32'h500, 0, 1, ALU_ADD, 1, 1, 0);
        step();
        set_dec(5'd4, 5'd1, 5'd5, 1, 1, 32'd0, 32'd1, 32'd0, 32'h504, 0, 0, ALU_ADD, 1, 0, 0);
        #1; cnt0 = m_cnt;
        n_checks++; if (dec_ready !== 1'b0) begin n_fail++; $display("FAIL lu_ready0: got %b expected 0", dec_ready); end
        step();
        n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble: got %b expected 0", ex_valid); end
        n_checks++; if (ex_reg_write !== 1'b0) begin n_fail++; $display("FAIL lu_bubble_rw: got %b expected 0", ex_reg_write); end
        n_checks++; if (stall_cnt !== cnt0 + 32'd1) begin n_fail++; $display("FAIL lu_cnt: got %0d expected %0d", stall_cnt, cnt0 + 32'd1); end
        n_checks++; if (dec_ready !== 1'b1) begin n_fail++; $display("FAIL lu_ready1: got %b expected 1", dec_ready); end
        step();
        n_checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd5) begin n_fail++; $display("FAIL lu_issue: got valid=%b rd=%0d expected valid=1 rd=5", ex_valid, ex_rd); end
        n_checks++; if (stall_cnt !== cnt0 + 32'd1) begin n_fail++; $display("FAIL lu_cnt_hold: got %0d expected %0d", stall_cnt, cnt0 + 32'd1); end
        $display("txn load_use: stall_cnt=%0d", stall_cnt);
    endtask

    task automatic test_flush_stall();
        logic [31:0] cnt0;
        set_dec(5'd0, 5'd0, 5'd9, 0, 0, 32'd1, 32'd2, 32'd3, 32'h600, 0, 0, ALU_OR, 1, 1, 1);
        ex_flush = 1; ex_stall = 1; cnt0 = m_cnt;
        #1;
        n_checks++; if (dec_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b expected 1", dec_ready); end
        step();
        n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", ex_valid); end
        n_checks++; if ({ex_reg_write, ex_mem_read, ex_mem_write} !== 3'b000) begin n_fail++; $display("FAIL flush_ctrl: got %b expected 000", {ex_reg_write, ex_mem_read, ex_mem_write}); end
        n_checks++; if (stall_cnt !== cnt0) begin n_fail++; $display("FAIL flush_cnt: got %0d expected %0d", stall_cnt, cnt0); end
        ex_flush = 0; ex_stall = 0;
        set_dec(5'd2, 5'd9, 5'd0, 1, 1, 32'd1, 32'd2, 32'd4, 32'h700, 0, 1, ALU_ADD, 0, 0, 1);
        step();
        set_dec(5'd0, 5'd0, 5'd12, 0, 0, 32'd0, 32'd0, 32'd0, 32'h704, 0, 0, ALU_XOR, 1, 0, 0);
        ex_stall = 1; #1;
        n_checks++; if (dec_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready: got %b expected 0", dec_ready); end
        step();
        n_checks++; if (ex_mem_write !== 1'b1 || ex_valid !== 1'b1 || ex_reg_write !== 1'b0) begin n_fail++; $display("FAIL stall_hold: got v=%b rw=%b mw=%b expected v=1 rw=0 mw=1", ex_valid, ex_reg_write, ex_mem_write); end
        n_checks++; if (ex_pc !== 32'h700) begin n_fail++; $display("FAIL stall_pc: got %h expected 700", ex_pc); end
        $display("txn flush_stall: ex_valid=%0b ex_pc=%h", ex_valid, ex_pc);
        idle(); step();
    endtask

    task automatic test_reset_mid_stall();
        set_dec(5'd1, 5'd0, 5'd4, 1, 0, 32'h2000, 32'd0, 32'd4, 32'h800, 0, 1, ALU_ADD, 1, 1, 0);
        step();
        set_dec(5'd2, 5'd4, 5'd5, 1, 1, 32'd3, 32'd0, 32'd0, 32'h804, 0, 0, ALU_SLL, 1, 0, 0);
        #1;
        n_checks++; if (dec_ready !== 1'b0) begin n_fail++; $display("FAIL rms_pending: got %b expected 0", dec_ready); end
        rst = 1; step();
        n_checks++; if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, dec_ready} !== 5'b0) begin n_fail++; $display("FAIL rms_ctrl: got %b expected 00000", {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, dec_ready}); end
        n_checks++; if ({ex_src_a, ex_src_b, ex_store_data, ex_pc} !== 128'd0) begin n_fail++; $display("FAIL rms_data: got %h %h %h %h expected 0", ex_src_a, ex_src_b, ex_store_data, ex_pc); end
        n_checks++; if (ex_rd !== 5'd0 || ex_alu_ctrl !== 3'd0) begin n_fail++; $display("FAIL rms_fields: got rd=%0d alu=%b expected 0", ex_rd, ex_alu_ctrl); end
        n_checks++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL rms_cnt: got %0d expected 0", stall_cnt); end
        rst = 0; idle();
        $display("txn reset_mid_stall: stall_cnt=%0d", stall_cnt);
    endtask

    task automatic test_random();
        bit exp_ready;
        for (int i = 0; i < 400; i++) begin
            dec_valid = ($urandom_range(0, 3) != 0);
            dec_rs1 = 5'($urandom_range(0, 7)); dec_rs2 = 5'($urandom_range(0, 7)); dec_rd = 5'($urandom_range(0, 7));
            dec_use_rs1 = 1'($urandom_range(0, 1)); dec_use_rs2 = 1'($urandom_range(0, 1));
            dec_rs1_data = $urandom(); dec_rs2_data = $urandom(); dec_imm = $urandom(); dec_pc = $urandom();
            dec_src_a_pc = 1'($urandom_range(0, 1)); dec_src_b_imm = 1'($urandom_range(0, 1));
            dec_alu_ctrl = 3'($urandom_range(0, 7));
            dec_funct7_bit = 1'($urandom_range(0, 1)); dec_funct3_bit0 = 1'($urandom_range(0, 1));
            dec_mem_read = ($urandom_range(0, 2) == 0); dec_reg_write = dec_mem_read | 1'($urandom_range(0, 1));
            dec_mem_write = !dec_mem_read && ($urandom_range(0, 3) == 0);
            mem_reg_write = ($urandom_range(0, 3) == 0); mem_rd = 5'($urandom_range(0, 7)); mem_result = $urandom();
            wb_reg_write = ($urandom_range(0, 3) == 0); wb_rd = 5'($urandom_range(0, 7)); wb_result = $urandom();
            ex_flush = ($urandom_range(0, 15) == 0); ex_stall = ($urandom_range(0, 7) == 0);
            #1;
            exp_ready = ex_flush ? 1'b1 : (ex_stall ? 1'b0 : !m_hazard());
            n_checks++; if (dec_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b expected %b", i, dec_ready, exp_ready); end
            n_checks++; if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write} !== {m_valid, m_rw, m_mr, m_mw}) begin n_fail++; $display("FAIL rnd_ctrl[%0d]: got %b expected %b", i, {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write}, {m_valid, m_rw, m_mr, m_mw}); end
            n_checks++; if (stall_cnt !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d expected %0d", i, stall_cnt, m_cnt); end
            if (m_valid) begin
                n_checks++; if (ex_src_a !== (m_apc ? m_pc : m_fwd(m_rs1, m_d1))) begin n_fail++; $display("FAIL rnd_src_a[%0d]: got %h expected %h", i, ex_src_a, m_apc ? m_pc : m_fwd(m_rs1, m_d1)); end
                n_checks++; if (ex_src_b !== (m_bimm ? m_imm : m_fwd(m_rs2, m_d2))) begin n_fail++; $display("FAIL rnd_src_b[%0d]: got %h expected %h", i, ex_src_b, m_bimm ? m_imm : m_fwd(m_rs2, m_d2)); end
                n_checks++; if (ex_store_data !== m_fwd(m_rs2, m_d2)) begin n_fail++; $display("FAIL rnd_store[%0d]: got %h expected %h", i, ex_store_data, m_fwd(m_rs2, m_d2)); end
                n_checks++; if ({ex_pc, ex_rd, ex_alu_ctrl, ex_funct7_bit, ex_funct3_bit0} !== {m_pc, m_rd, m_alu, m_f7, m_f3}) begin n_fail++; $display("FAIL rnd_fields[%0d]: got %h expected %h", i, {ex_pc, ex_rd, ex_alu_ctrl, ex_funct7_bit, ex_funct3_bit0}, {m_pc, m_rd, m_alu, m_f7, m_f3}); end
            end
            $display("txn rnd %0d: dec_valid=%0b flush=%0b stall=%0b ready=%0b ex_valid=%0b ex_rd=%0d stall_cnt=%0d",
                     i, dec_valid, ex_flush, ex_stall, dec_ready, ex_valid, ex_rd, stall_cnt);
            step();
        end
        idle();
    endtask

    initial begin
        idle();
        set_dec(5'd0, 5'd0, 5'd0, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0, 3'd0, 0, 0, 0);
        dec_valid = 0; mem_rd = 0; mem_result = 0; wb_rd = 0; wb_result = 0;
        test_reset();
        test_add();
        test_mem_priority();
        test_x0();
        test_load_use();
        test_flush_stall();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL use one clock and one synchronous, active-high reset: clk (rising edge) and rst.
REQ-002 clk  in  1  stage clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 dec_valid  in  1  decode holds a valid instruction.
REQ-005 dec_rs1/dec_rs2/dec_rd  in  5 each  register indices.
REQ-006 dec_use_rs1/dec_use_rs2  in  1 each  instruction reads that source.
REQ-007 dec_rs1_data/dec_rs2_data/dec_imm/dec_pc  in  32 each  register-file reads, immediate, PC.
REQ-008 dec_src_a_pc/dec_src_b_imm  in  1 each  operand A = PC, operand B = immediate.
REQ-009 dec_alu_ctrl  in  3  ALU op; dec_funct7_bit/dec_funct3_bit0  in  1 each  SRA and SLTU qualifiers.
REQ-010 dec_reg_write/dec_mem_read/dec_mem_write  in  1 each  control bits.
REQ-011 mem_reg_write, mem_rd[4:0], mem_result[31:0]  in  MEM-stage writer; wb_reg_write, wb_rd[4:0], wb_result[31:0]  in  WB-stage writer.
REQ-012 ex_stall  in  1  downstream hold; ex_flush  in  1  kill EX contents (taken branch).
REQ-013 dec_ready  out  1  decode instruction accepted this cycle.
REQ-014 ex_valid  out  1; ex_src_a/ex_src_b/ex_store_data/ex_pc  out  32 each  ALU operands, rs2 value for stores, PC.
REQ-015 ex_alu_ctrl[2:0], ex_funct7_bit, ex_funct3_bit0, ex_rd[4:0], ex_reg_write, ex_mem_read, ex_mem_write  out  registered decode fields.
REQ-016 stall_cnt  out  32  cycles in which a hazard bubble was inserted.

Function
REQ-017 EX register update priority SHALL be: rst > ex_flush > ex_stall > hazard bubble > load.
REQ-018 ex_flush SHALL load a bubble next cycle (ex_valid=0, ex_reg_write=ex_mem_read=ex_mem_write=0) regardless of ex_stall or dec_valid; dec_ready=1 in that cycle.
REQ-019 ex_stall without flush SHALL hold every EX register unchanged; dec_ready=0.
REQ-020 Hazard: ex_valid & ex_mem_read & ex_rd!=0 & ((dec_use_rs1 & dec_rs1==ex_rd) | (dec_use_rs2 & dec_rs2==ex_rd)) with dec_valid SHALL force dec_ready=0 and load a bubble; held decode retries next cycle.
REQ-021 Otherwise the EX register SHALL capture all dec_* fields, ex_valid=dec_valid, control bits gated by dec_valid; dec_ready=1.
REQ-022 Forwarding (combinational, EX cycle) per source using registered index and raw data: MEM match (mem_reg_write, mem_rd!=0, equal) wins over WB match; else registered register-file data.
REQ-023 Register x0 SHALL never be forwarded or cause a hazard.
REQ-024 ex_src_a = ex_pc if src_a_pc else forwarded rs1; ex_src_b = immediate if src_b_imm else forwarded rs2; ex_store_data = forwarded rs2 always.
REQ-025 stall_cnt SHALL increment by 1 in each cycle REQ-020 inserts a bubble (not on ex_stall or flush), wrapping 0xFFFFFFFF->0.
REQ-026 Latency: decode accepted at edge N appears on ex_* outputs in cycle N+1.

Reset
REQ-027 rst SHALL at the next edge clear ex_valid, all control outputs, all 32-bit registers, ex_rd, ex_alu_ctrl and stall_cnt to 0; mid-stall reset discards the held instruction.
REQ-028 During rst high dec_ready SHALL be 0.

Configuration
REQ-029 Macro FORWARDING_EN defined: REQ-022 forwarding active, hazard per REQ-020 only.
REQ-030 FORWARDING_EN undefined: no forwarding (registered register-file data used); REQ-020 extends to any decode source matching a writing non-x0 rd in EX (valid), MEM or WB, each such cycle counted by stall_cnt.

Structure
REQ-031 ALU op encodings (ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLL 101, SRL/SRA 110, SLT/SLTU 111) and the 5-bit register-index type SHALL live in the shared riscv_pkg.
REQ-032 Forwarding select logic SHALL be one combinational sub-module, forward_unit, instantiated twice (rs1, rs2).

Verification
REQ-033 ADD x3,x1,x2 with x1=5,x2=7 -> next cycle ex_src_a=5, ex_src_b=7, ex_alu_ctrl=000, ex_valid=1.
REQ-034 EX=ADD rd=x3 in MEM (mem_result=0x0C), WB rd=x3 (wb_result=0x99), EX reads x3 -> ex_src_a=0x0C (MEM priority).
REQ-035 LW x4 in EX, decode ADD x5,x4,x1 -> dec_ready=0 one cycle, bubble, stall_cnt 0->1, ADD issues next cycle.
REQ-036 ex_flush=1 and ex_stall=1 together with valid EX -> next cycle ex_valid=0, controls 0, stall_cnt unchanged.
REQ-037 mem_rd=0, mem_reg_write=1, mem_result=0xFFFFFFFF, EX reads x0 with data 0 -> ex_src_a=0.
REQ-038 rst asserted while load-use stall pending -> next cycle all outputs 0, stall_cnt=0.
